ram_dump_engine: RTL and testbench
==================================

RAM_DUMP_ENGINE -- requirements
Module: ram_dump_engine

Interface
REQ-001 SHALL have parameter ADDR_BITS, default `ADDRESS_BITS, RAM address width.
REQ-002 SHALL have parameter DATA_BITS, default `DATA_BITS, RAM word width; an integer multiple of 8, at least 8.
REQ-003 SHALL have derived constant BYTES = DATA_BITS/8, bytes per word.
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin dump; sampled in IDLE only.
- abort  in  1  cancel dump in progress.
- startAddr  in  ADDR_BITS  first word address; latched on accepted start.
- endAddr  in  ADDR_BITS  last word address; latched on accepted start.
- clearAfterRead  in  1  zero each word after sending; latched on accepted start.
- dataOut  in  DATA_BITS  RAM read data.
- dataIn  out  DATA_BITS  RAM write data; constant 0.
- address  out  ADDR_BITS  RAM address.
- readWriteMode  out  1  `RAM_READ or `RAM_WRITE.
- txReady  in  1  UART transmitter idle.
- txSignalStart  out  1  one-cycle byte-send strobe.
- txData  out  8  byte to transmit.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle pulse on normal completion.

Function
REQ-005 SHALL implement states IDLE, READ, LATCH, WAIT_TX, SEND, CLEAR, NEXT, CHK_WAIT, CHK_SEND.
REQ-006 SHALL, in IDLE with start=1, latch the inputs, load the current address with startAddr and enter READ; a start while busy SHALL be ignored.
REQ-007 SHALL drive address = current address in READ, LATCH and CLEAR; RAM read latency is one cycle.
REQ-008 SHALL, in LATCH, capture dataOut into a DATA_BITS shift register, set byteCount=0 and go to WAIT_TX.
REQ-009 SHALL stay in WAIT_TX while txReady=0 and go to SEND when txReady=1.
REQ-010 SHALL, in SEND, assert txSignalStart for exactly one cycle with txData equal to the most significant unsent byte (MSB first), then shift by 8 and increment byteCount.
REQ-011 SHALL, after SEND, return to WAIT_TX if byteCount<BYTES, else go to CLEAR if clearAfterRead=1, else to NEXT.
REQ-012 SHALL, in CLEAR, hold readWriteMode=`RAM_WRITE for one cycle with dataIn=0; in every other state readWriteMode SHALL be `RAM_READ.
REQ-013 SHALL, in NEXT, complete if current address==endAddr; otherwise increment the address modulo 2^ADDR_BITS and go to READ.
REQ-014 SHALL, when endAddr<startAddr, dump through the wrap from all-ones to 0; startAddr==endAddr dumps exactly one word; startAddr==endAddr+1 dumps all 2^ADDR_BITS words.
REQ-015 SHALL, on completion, pulse finished for one cycle (in NEXT, or in CHK_SEND when checksum is enabled) and return to IDLE.
REQ-016 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle with no txSignalStart, no RAM write and no finished pulse; abort SHALL take priority over every other transition in that cycle.
REQ-017 SHALL give a start-to-first-strobe latency of 4 cycles with txReady held high: start accepted at cycle 0, READ at 1, LATCH at 2, WAIT_TX at 3, SEND at 4.

Reset
REQ-018 SHALL, while reset=1, hold the state at IDLE and drive address=0, txSignalStart=0, txData=0, busy=0, finished=0, readWriteMode=`RAM_READ; all internal registers SHALL clear.
REQ-019 SHALL, on reset mid-dump, discard the dump with no finished pulse; the state after reset is identical to power-up.

Configuration
REQ-020 SHALL, with macro RAM_DUMP_ENGINE_CHECKSUM_EN defined, accumulate an 8-bit sum (mod 256) of all sent bytes, clear it on accepted start, and send it once via CHK_WAIT/CHK_SEND after the last word's NEXT.
REQ-021 SHALL, without the macro, have no checksum logic or states; NEXT completes directly.

Structure
REQ-022 SHALL take state encodings and the `RAM_READ/`RAM_WRITE values from the shared defaults package.
REQ-023 SHALL place the word shift register and byte counter in one sub-module, word_serializer.

Verification
REQ-024 SHALL cover: ADDR_BITS=4, DATA_BITS=16, RAM[2]=0xA55A, start 2..2, txReady=1 -> bytes 0xA5, 0x5A; strobe at cycle 4; finished once.
REQ-025 SHALL cover: start 14..1 -> addresses 14, 15, 0, 1 in order, 8 bytes.
REQ-026 SHALL cover: clearAfterRead=1 over 0..3 -> RAM[0..3]=0 afterwards; exactly 4 write cycles.
REQ-027 SHALL cover: txReady low for 10 cycles in WAIT_TX -> no strobe until txReady is high; byte order preserved.
REQ-028 SHALL cover: abort during the second word -> IDLE next cycle, no finished, a following start is accepted.
REQ-029 SHALL cover: macro defined, DATA_BITS=8, words 0x01, 0x02, 0xFF -> trailing byte 0x02; macro undefined -> 3 bytes only.

Source files
------------

// File: rtl/ram_dump_engine_pkg.sv
// Shared defaults for the RAM dump engine: widths, RAM access codes and state encoding.
// The checksum states only exist when RAM_DUMP_ENGINE_CHECKSUM_EN is defined.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

package ram_dump_engine_pkg;

  localparam logic RAM_READ_MODE  = `RAM_READ;
  localparam logic RAM_WRITE_MODE = `RAM_WRITE;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    READ     = 4'd1,
    LATCH    = 4'd2,
    WAIT_TX  = 4'd3,
    SEND     = 4'd4,
    CLEAR    = 4'd5,
    NEXT     = 4'd6
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
    ,
    CHK_WAIT = 4'd7,
    CHK_SEND = 4'd8
`endif
  } dumpState_t;

endpackage

// File: rtl/ram_dump_engine_word_serializer.sv
// Holds one RAM word and hands it out a byte at a time, most significant byte first.
// lastByte flags that the byte currently on topByte is the final one of the word.
module word_serializer
  import ram_dump_engine_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BYTES     = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] word,
  output logic [7:0]           topByte,
  output logic                 lastByte
);

  localparam int COUNT_BITS = $clog2(BYTES) + 1;

  logic [DATA_BITS-1:0]  shiftReg;
  logic [COUNT_BITS-1:0] byteCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg  <= '0;
      byteCount <= '0;
    end else if (load) begin
      shiftReg  <= word;
      byteCount <= '0;
    end else if (shift) begin
      shiftReg  <= shiftReg << 8;
      byteCount <= byteCount + COUNT_BITS'(1);
    end
  end

  assign topByte  = shiftReg[DATA_BITS-1 -: 8];
  assign lastByte = (byteCount == COUNT_BITS'(BYTES - 1));

endmodule

// File: rtl/ram_dump_engine.sv
// Streams an inclusive, wrap-capable RAM address range out over a byte UART, MSB first.
// Define RAM_DUMP_ENGINE_CHECKSUM_EN to append a mod-256 sum of all sent bytes.
module ram_dump_engine
  import ram_dump_engine_pkg::*;
#(
  parameter int ADDR_BITS = `ADDRESS_BITS,
  parameter int DATA_BITS = `DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] startAddr,
  input  logic [ADDR_BITS-1:0] endAddr,
  input  logic                 clearAfterRead,
  input  logic [DATA_BITS-1:0] dataOut,
  output logic [DATA_BITS-1:0] dataIn,
  output logic [ADDR_BITS-1:0] address,
  output logic                 readWriteMode,
  input  logic                 txReady,
  output logic                 txSignalStart,
  output logic [7:0]           txData,
  output logic                 busy,
  output logic                 finished
);

  // state    | meaning
  // IDLE     | waiting for start
  // READ     | address presented to RAM
  // LATCH    | RAM data valid, captured into serializer
  // WAIT_TX  | waiting for UART idle
  // SEND     | one-cycle byte strobe
  // CLEAR    | zero the word just sent
  // NEXT     | finish or step to next address
  // CHK_WAIT | waiting for UART idle before checksum
  // CHK_SEND | checksum byte strobe

  localparam int BYTES = DATA_BITS / 8;

  dumpState_t           state, nextState;
  logic [ADDR_BITS-1:0] curAddr, lastAddr;
  logic                 clearReg, loadWord, shiftByte, lastByte, atEnd;
  logic [7:0]           topByte;
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
  logic [7:0]           checksum;
`endif

  assign atEnd  = (curAddr == lastAddr);
  assign dataIn = '0;

  word_serializer #(
    .DATA_BITS(DATA_BITS),
    .BYTES    (BYTES)
  ) serializer (
    .clk     (clk),
    .reset   (reset),
    .load    (loadWord),
    .shift   (shiftByte),
    .word    (dataOut),
    .topByte (topByte),
    .lastByte(lastByte)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curAddr  <= '0;
      lastAddr <= '0;
      clearReg <= 1'b0;
    end else if (state == IDLE && start) begin
      curAddr  <= startAddr;
      lastAddr <= endAddr;
      clearReg <= clearAfterRead;
    end else if (state == NEXT && !abort && !atEnd) begin
      curAddr  <= curAddr + ADDR_BITS'(1);
    end
  end

`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (shiftByte)              checksum <= checksum + topByte;
  end
`endif

  // Abort outranks every other transition out of a busy state.
  always_comb begin
    nextState = state;
    if (state != IDLE && abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) nextState = READ;
        READ:    nextState = LATCH;
        LATCH:   nextState = WAIT_TX;
        WAIT_TX: if (txReady) nextState = SEND;
        SEND: begin
          if (!lastByte)    nextState = WAIT_TX;
          else if (clearReg) nextState = CLEAR;
          else              nextState = NEXT;
        end
        CLEAR:   nextState = NEXT;
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
        NEXT:     nextState = atEnd ? CHK_WAIT : READ;
        CHK_WAIT: if (txReady) nextState = CHK_SEND;
        CHK_SEND: nextState = IDLE;
`else
        NEXT:    nextState = atEnd ? IDLE : READ;
`endif
        default: nextState = IDLE;
      endcase
    end
  end

  // Side effects are suppressed in an abort cycle so a cancelled dump leaves no trace.
  always_comb begin
    address       = '0;
    readWriteMode = RAM_READ_MODE;
    txSignalStart = 1'b0;
    txData        = '0;
    busy          = 1'b0;
    finished      = 1'b0;
    loadWord      = 1'b0;
    shiftByte     = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        READ:  address = curAddr;
        LATCH: begin
          address  = curAddr;
          loadWord = !abort;
        end
        SEND: begin
          txSignalStart = !abort;
          txData        = topByte;
          shiftByte     = !abort;
        end
        CLEAR: begin
          address = curAddr;
          if (!abort) readWriteMode = RAM_WRITE_MODE;
        end
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
        CHK_SEND: begin
          txSignalStart = !abort;
          txData        = checksum;
          finished      = !abort;
        end
`else
        NEXT:  finished = !abort && atEnd;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_engine.sv
// Randomized bench for ram_dump_engine: a range-level dump model predicts bytes, writes and RAM.
// Honours RAM_DUMP_ENGINE_CHECKSUM_EN by expecting the trailing checksum byte.
module tb_ram_dump_engine;
  import ram_dump_engine_pkg::*;

  localparam int AB     = 4;
  localparam int DB     = 16;
  localparam int NWORDS = 1 << AB;
  localparam int NBYTES = DB / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          clearAfterRead = 1'b0;
  logic [AB-1:0] startAddr = '0;
  logic [AB-1:0] endAddr = '0;
  logic [DB-1:0] dataOut;
  logic [DB-1:0] dataIn;
  logic [AB-1:0] address;
  logic          readWriteMode;
  logic          txReady = 1'b0;
  logic          txSignalStart;
  logic [7:0]    txData;
  logic          busy;
  logic          finished;

  logic          startB = 1'b0;
  logic          abortB = 1'b0;
  logic          clearB = 1'b0;
  logic [AB-1:0] startAddrB = 4'd0;
  logic [AB-1:0] endAddrB = 4'd2;
  logic [7:0]    dataOutB;
  logic [7:0]    dataInB;
  logic [AB-1:0] addressB;
  logic          readWriteModeB;
  logic          txSignalStartB;
  logic [7:0]    txDataB;
  logic          busyB;
  logic          finishedB;

  logic [DB-1:0] ram    [NWORDS];
  logic [DB-1:0] refRam [NWORDS];
  logic [7:0]    ramB   [NWORDS];

  logic [7:0]    gotQ[$];
  logic [AB-1:0] wrAddrQ[$];
  logic [7:0]    gotQB[$];
  int            finCnt = 0;
  int            finCntB = 0;
  int            txMode = 0;
  int            assertCnt = 0;
  int            failCnt = 0;

  always #5 clk = ~clk;

  ram_dump_engine #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .startAddr(startAddr), .endAddr(endAddr), .clearAfterRead(clearAfterRead),
    .dataOut(dataOut), .dataIn(dataIn), .address(address), .readWriteMode(readWriteMode),
    .txReady(txReady), .txSignalStart(txSignalStart), .txData(txData),
    .busy(busy), .finished(finished)
  );

  ram_dump_engine #(.ADDR_BITS(AB), .DATA_BITS(8)) dutB (
    .clk(clk), .reset(reset), .start(startB), .abort(abortB),
    .startAddr(startAddrB), .endAddr(endAddrB), .clearAfterRead(clearB),
    .dataOut(dataOutB), .dataIn(dataInB), .address(addressB), .readWriteMode(readWriteModeB),
    .txReady(txReady), .txSignalStart(txSignalStartB), .txData(txDataB),
    .busy(busyB), .finished(finishedB)
  );

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (readWriteMode == RAM_WRITE_MODE) ram[address] <= dataIn;
    dataOut <= ram[address];
    if (readWriteModeB == RAM_WRITE_MODE) ramB[addressB] <= dataInB;
    dataOutB <= ramB[addressB];
  end

  always @(posedge clk) begin
    #2;
    if (txMode == 0)      txReady = 1'b1;
    else if (txMode == 1) txReady = ($urandom_range(0, 3) != 0);
    else                  txReady = 1'b0;
  end

  always @(negedge clk) begin
    if (txSignalStart) gotQ.push_back(txData);
    if (finished) finCnt++;
    if (readWriteMode == RAM_WRITE_MODE) wrAddrQ.push_back(address);
    if (txSignalStartB) gotQB.push_back(txDataB);
    if (finishedB) finCntB++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setWord(input int a, input logic [DB-1:0] v);
    refRam[a] = v;
    ram[a] <= v;
  endtask

  task automatic loadRandom();
    for (int i = 0; i < NWORDS; i++) setWord(i, DB'($urandom));
  endtask

  // Model: the inclusive range s..e modulo NWORDS, each word MSB byte first.
  task automatic runDump(input logic [AB-1:0] s, input logic [AB-1:0] e, input logic clr,
                         input int mode, input int holdLow);
    logic [7:0]    expQ[$];
    int            expAddr[$];
    logic [7:0]    sum;
    logic [7:0]    byteVal;
    int            n, a, base, wbase, fbase, cyc, first, mism;
    n = ((int'(e) - int'(s) + NWORDS) % NWORDS) + 1;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      a = (int'(s) + i) % NWORDS;
      for (int b = NBYTES - 1; b >= 0; b--) begin
        byteVal = refRam[a][8*b +: 8];
        expQ.push_back(byteVal);
        sum = sum + byteVal;
      end
      if (clr) begin
        refRam[a] = '0;
        expAddr.push_back(a);
      end
    end
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
    expQ.push_back(sum);
`endif
    base  = gotQ.size();
    wbase = wrAddrQ.size();
    fbase = finCnt;
    txMode = (holdLow > 0) ? 2 : mode;
    startAddr = s;
    endAddr = e;
    clearAfterRead = clr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    first = -1;
    while (!finished && cyc < 3000) begin
      if (txSignalStart && first < 0) first = cyc;
      if (holdLow > 0 && cyc == holdLow) begin
        checkVal("noStrobeWhileLow", gotQ.size() - base, 0);
        txMode = mode;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (txSignalStart && first < 0) first = cyc;
    checkVal("dumpTimeout", cyc < 3000, 1);
    if (mode == 0 && holdLow == 0) checkVal("firstStrobeLatency", first, 4);
    repeat (2) @(posedge clk);
    #1;
    checkVal("finishedCount", finCnt - fbase, 1);
    checkVal("busyAfter", busy, 0);
    checkVal("byteCount", gotQ.size() - base, expQ.size());
    for (int i = 0; i < expQ.size() && base + i < gotQ.size(); i++)
      checkVal($sformatf("byte[%0d]", i), gotQ[base + i], expQ[i]);
    checkVal("writeCount", wrAddrQ.size() - wbase, expAddr.size());
    for (int i = 0; i < expAddr.size() && wbase + i < wrAddrQ.size(); i++)
      checkVal($sformatf("writeAddr[%0d]", i), wrAddrQ[wbase + i], expAddr[i]);
    mism = 0;
    for (int i = 0; i < NWORDS; i++) if (ram[i] !== refRam[i]) mism++;
    checkVal("ramContents", mism, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expB[$];
    int         base, fbase, cyc;
    for (int i = 0; i < NWORDS; i++) begin
      setWord(i, '0);
      ramB[i] <= 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstBusy", busy, 0);
    checkVal("rstAddress", address, 0);
    checkVal("rstStrobe", txSignalStart, 0);
    checkVal("rstTxData", txData, 0);
    checkVal("rstFinished", finished, 0);
    checkVal("rstRwMode", readWriteMode, RAM_READ_MODE);
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("idleBusy", busy, 0);

    // Single word, fixed pattern.
    loadRandom();
    setWord(2, 16'hA55A);
    runDump(4'd2, 4'd2, 1'b0, 0, 0);
    // Wrap through all-ones, then a full-circle range, then clearing.
    loadRandom();
    runDump(4'd14, 4'd1, 1'b0, 0, 0);
    runDump(4'd5, 4'd4, 1'b0, 1, 0);
    runDump(4'd0, 4'd3, 1'b1, 0, 0);
    // Transmitter busy for a long stretch before the first byte.
    loadRandom();
    runDump(4'd7, 4'd8, 1'b0, 0, 13);

    // Abort while strobing the second byte of the second word.
    loadRandom();
    base = gotQ.size();
    fbase = finCnt;
    startAddr = 4'd0;
    endAddr = 4'd3;
    clearAfterRead = 1'b0;
    txMode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(txSignalStart && (gotQ.size() - base) == 3) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkVal("abortReach", cyc < 200, 1);
    abort = 1'b1;
    #1;
    checkVal("abortNoStrobe", txSignalStart, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    checkVal("abortIdle", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    checkVal("abortBytes", gotQ.size() - base, 3);
    checkVal("abortNoFinish", finCnt - fbase, 0);
    runDump(4'd3, 4'd6, 1'b0, 0, 0);

    // Reset in the middle of a dump.
    fbase = finCnt;
    startAddr = 4'd4;
    endAddr = 4'd9;
    clearAfterRead = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("postRstBusy", busy, 0);
    checkVal("postRstAddress", address, 0);
    checkVal("midRstNoFinish", finCnt - fbase, 0);
    runDump(4'd9, 4'd11, 1'b1, 0, 0);

    for (int it = 0; it < 24; it++) begin
      loadRandom();
      runDump(AB'($urandom), AB'($urandom), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 0);
    end

    // Byte-wide instance: words 0x01, 0x02, 0xFF; checksum would be 0x02.
    ramB[0] <= 8'h01;
    ramB[1] <= 8'h02;
    ramB[2] <= 8'hFF;
    expB = '{8'h01, 8'h02, 8'hFF};
`ifdef RAM_DUMP_ENGINE_CHECKSUM_EN
    expB.push_back(8'h02);
`endif
    txMode = 0;
    base = gotQB.size();
    fbase = finCntB;
    @(posedge clk); #1;
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    cyc = 0;
    while (!finishedB && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkVal("byteWideTimeout", cyc < 500, 1);
    repeat (2) @(posedge clk);
    #1;
    checkVal("byteWideFinished", finCntB - fbase, 1);
    checkVal("byteWideCount", gotQB.size() - base, expB.size());
    for (int i = 0; i < expB.size() && base + i < gotQB.size(); i++)
      checkVal($sformatf("byteWide[%0d]", i), gotQB[base + i], expB[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
